// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Single-outstanding instruction fetch front end. It issues one word fetch
//   at a time and holds the returned instruction for decode until it is
//   consumed. It then redirects the PC sequentially, to a branch target, or to
//   a flush target. A fetch that is still in flight when a flush arrives is
//   squashed: it is allowed to complete on the memory side, but its data is
//   dropped.
//
// Ports:
//   clk           in   1   clock, rising edge
//   reset         in   1   synchronous active-high reset
//   imem_req      out  1   fetch request (held until imem_ack)
//   imem_addr     out  19  word address of the current fetch
//   imem_ack      in   1   fetch completes, imem_rdata valid
//   imem_rdata    in   21  fetched instruction word
//   inst          out  21  held instruction for decode
//   inst_pc       out  19  address of inst
//   inc_pc        out  19  inst_pc + 1 (mod 2^19)
//   inst_valid    out  1   inst/inst_pc/inc_pc valid
//   inst_ready    in   1   decode consumes inst this cycle
//   pc_src        in   1   consumed instruction redirects to target_addr
//   target_addr   in   19  branch/jump target
//   flush         in   1   redirect to flush_target, any cycle
//   flush_target  in   19  redirect address
//
// State  | meaning
// -------+-------------------------------------------------------------------
// FETCH  | request outstanding at pc; data is kept on ack
// SQUASH | request outstanding at pc; data is dropped on ack, pc <- pending
// HOLD   | instruction held for decode, no request
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [18:0] RESET_PC = 19'h00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [18:0] imem_addr,
    input  logic        imem_ack,
    input  logic [20:0] imem_rdata,
    output logic [20:0] inst,
    output logic [18:0] inst_pc,
    output logic [18:0] inc_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        pc_src,
    input  logic [18:0] target_addr,
    input  logic        flush,
    input  logic [18:0] flush_target
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_SQUASH = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    logic [18:0] r_pc;
    logic [18:0] r_pend;
    logic [20:0] r_inst;
    logic [18:0] r_inst_pc;
    logic [18:0] r_inc_pc;
    logic        r_inst_valid;

    state_t      w_state_nxt;
    logic [18:0] w_pc_nxt;
    logic [18:0] w_pend_nxt;
    logic [20:0] w_inst_nxt;
    logic [18:0] w_inst_pc_nxt;
    logic [18:0] w_inc_pc_nxt;
    logic        w_valid_nxt;
    logic        w_consume;
    logic        w_imem_req;

    assign w_consume = r_inst_valid & inst_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_pend       <= 19'h00000;
            r_inst       <= 21'h000000;
            r_inst_pc    <= 19'h00000;
            r_inc_pc     <= 19'h00000;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend       <= w_pend_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inc_pc     <= w_inc_pc_nxt;
            r_inst_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_inc_pc_nxt  = r_inc_pc;
        w_valid_nxt   = r_inst_valid;
        w_imem_req    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (flush) begin
                    if (imem_ack) begin
                        // The fetch retires this cycle, so its data is simply
                        // dropped and the next request starts at the flush target.
                        w_pc_nxt = flush_target;
                    end else begin
                        // The request must stay stable until it is acked, so the
                        // redirect is parked in the pending register.
                        w_pend_nxt  = flush_target;
                        w_state_nxt = S_SQUASH;
                    end
                end else if (imem_ack) begin
                    w_inst_nxt    = imem_rdata;
                    w_inst_pc_nxt = r_pc;
                    w_inc_pc_nxt  = r_pc + 19'd1;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_HOLD;
                end
            end

            S_SQUASH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_pc_nxt    = flush ? flush_target : r_pend;
                    w_state_nxt = S_FETCH;
                end else if (flush) begin
                    w_pend_nxt = flush_target;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    // A flush takes priority over any branch decision made on a
                    // simultaneous consume.
                    w_pc_nxt    = flush_target;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_FETCH;
                end else if (w_consume) begin
                    w_pc_nxt    = pc_src ? target_addr : r_inc_pc;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign imem_req   = w_imem_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inc_pc     = r_inc_pc;
    assign inst_valid = r_inst_valid;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 19'h00000, meaning the word address of the first fetch after reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port imem_req  output  1  instruction-memory fetch request.
REQ-005 SHALL provide port imem_addr  output  19  word address of the current fetch.
REQ-006 SHALL provide port imem_ack  input  1  memory completes the fetch; imem_rdata valid this cycle.
REQ-007 SHALL provide port imem_rdata  input  21  fetched instruction word.
REQ-008 SHALL provide port inst  output  21  held instruction presented to decode.
REQ-009 SHALL provide port inst_pc  output  19  address of inst.
REQ-010 SHALL provide port inc_pc  output  19  inst_pc+1, modulo 2^19, feeding next-PC/branch-target logic.
REQ-011 SHALL provide port inst_valid  output  1  inst/inst_pc/inc_pc are valid.
REQ-012 SHALL provide port inst_ready  input  1  decode consumes the held instruction this cycle.
REQ-013 SHALL provide port pc_src  input  1  taken branch/jump for the consumed instruction; sampled only on a consume.
REQ-014 SHALL provide port target_addr  input  19  next PC when pc_src=1.
REQ-015 SHALL provide port flush  input  1  asynchronous-to-pipeline redirect (exception/restart), any cycle.
REQ-016 SHALL provide port flush_target  input  19  next PC when flush=1.

Function
REQ-017 SHALL implement states FETCH, SQUASH and HOLD, plus a 19-bit pc register and a 19-bit pending-target register.
REQ-018 SHALL, in FETCH and SQUASH, drive imem_req=1 with imem_addr=pc; in HOLD, imem_req=0.
REQ-019 SHALL, once imem_req is asserted, hold imem_req and imem_addr stable until the cycle imem_ack=1; a zero-wait ack in the first request cycle is legal.
REQ-020 SHALL, in FETCH with imem_ack=1 and flush=0, latch inst=imem_rdata, inst_pc=pc, inc_pc=pc+1, set inst_valid=1 and go to HOLD next cycle.
REQ-021 SHALL, in HOLD, keep inst_valid=1 and inst/inst_pc/inc_pc unchanged until consume (inst_valid & inst_ready).
REQ-022 SHALL, on consume with flush=0, set pc to target_addr if pc_src=1 else inc_pc, clear inst_valid and enter FETCH next cycle (one bubble cycle minimum between instructions).
REQ-023 SHALL ignore pc_src and target_addr in every cycle without a consume.
REQ-024 SHALL, on flush in HOLD (with or without inst_ready), clear inst_valid, set pc=flush_target and enter FETCH; a simultaneous inst_ready still counts as consumed, but pc_src is ignored.
REQ-025 SHALL, on flush in FETCH with imem_ack=0, store flush_target as the pending target and enter SQUASH, keeping the request stable.
REQ-026 SHALL, on flush in FETCH with imem_ack=1, discard imem_rdata, set pc=flush_target and stay in FETCH.
REQ-027 SHALL, in SQUASH, overwrite the pending target on any further flush (last flush wins), and on imem_ack discard imem_rdata, load pc from the pending target and enter FETCH; a flush coinciding with that ack uses its own flush_target.
REQ-028 SHALL never assert inst_valid for a fetch that was outstanding when a flush occurred.
REQ-029 SHALL wrap pc+1 from 19'h7FFFF to 19'h00000 without error.

Reset
REQ-030 SHALL, while reset=1, override all inputs and force: state=FETCH, pc=RESET_PC, pending target=0, inst=0, inst_pc=0, inc_pc=0, inst_valid=0.
REQ-031 SHALL, in the first cycle after reset deasserts, drive imem_req=1 with imem_addr=RESET_PC.
REQ-032 SHALL, on reset mid-fetch, abandon the outstanding request; the instruction memory is reset by the same reset and SHALL NOT return the abandoned ack.

Verification
REQ-033 SHALL verify reset-then-fetch: release reset, ack after 2 cycles with rdata=21'h0ABCD -> inst_valid=1, inst=21'h0ABCD, inst_pc=0, inc_pc=1.
REQ-034 SHALL verify sequential flow: consume at pc=5, pc_src=0 -> next imem_addr=6; consume at pc=6, pc_src=1, target_addr=19'h00040 -> next imem_addr=19'h00040.
REQ-035 SHALL verify squash: flush=1, flush_target=19'h00100 while fetch of pc=8 awaits ack; ack 3 cycles later -> no inst_valid, then imem_addr=19'h00100.
REQ-036 SHALL verify double flush in SQUASH: targets 19'h00100 then 19'h00200 before ack -> next fetch address 19'h00200.
REQ-037 SHALL verify wrap and stall: inst_pc=19'h7FFFF held with inst_ready=0 for 4 cycles -> outputs stable, imem_req=0; then consume with pc_src=0 -> inc_pc=0 and imem_addr=0.
REQ-038 SHALL verify flush+consume collision in HOLD: inst_ready=1, pc_src=1, target_addr=19'h00010, flush=1, flush_target=19'h00300 -> next imem_addr=19'h00300.
